// File: rtl/fdiv_pkg.sv
`timescale 1ns/1ps
// Shared constants for the fdiv family of synchronous power-of-two clock dividers.
package fdiv_pkg;

  localparam int unsigned N_BITS_DEFAULT = 4;

  // Input-to-output division ratio for a counter of the given width.
  function automatic int unsigned div_ratio(input int unsigned n_bits);
    return 32'd1 << n_bits;
  endfunction

endpackage

// File: rtl/fdiv16_sync.sv
`timescale 1ns/1ps
// Synchronous clock divider: one binary up-counter on the input clock; every output
// is a direct counter flop bit, so all taps switch on the same edge with no ripple.
module fdiv16_sync
  import fdiv_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEFAULT
) (
  input  logic              in,
  input  logic              rst_n,
  input  logic              en,
  output logic              out,
  output logic [N_BITS-1:0] taps,
  output logic [N_BITS-1:0] cnt
);

  logic [N_BITS-1:0] cnt_q;
  logic [N_BITS-1:0] cnt_d;

  // NOTE: a ternary instead of if (en) so an unknown enable turns the count unknown
  // rather than being silently treated as a hold.
  assign cnt_d = en ? cnt_q + N_BITS'(1) : cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // reader sees the pre-edge value and all counter bits switch together.
  always_ff @(posedge in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign taps = cnt_q;
  assign out  = cnt_q[N_BITS-1];

endmodule

// File: tb/tb_fdiv16_sync.sv
`timescale 1ns/1ps
// Self-checking bench for fdiv16_sync: an N_BITS=4 instance plus N_BITS=1 and N_BITS=8
// instances, compared against an enabled-edge-count model and measured edge times.
module tb_fdiv16_sync;
  import fdiv_pkg::*;

  typedef struct {
    logic en;
    int   cycles;
    int   exp_cnt;
    logic exp_out;
  } vec_t;

  typedef struct {
    realtime r0;
    realtime f0;
    realtime r1;
    int      nr;
    int      nf;
  } edge_rec_t;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en;
  logic       out4, out1, out8;
  logic [3:0] taps4, cnt4;
  logic [0:0] taps1, cnt1;
  logic [7:0] taps8, cnt8;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned n_en     = 0;
  bit          rec      = 1'b0;
  realtime     t_pos    = 0.0;
  realtime     t_rel    = 0.0;
  int          misaligned = 0;
  logic [3:0]  taps_prev  = '0;
  realtime     tap_r0[4];
  realtime     tap_r1[4];
  int          tap_nr[4];
  edge_rec_t   rec4, rec1, rec8;
  vec_t        vecs[9];

  // 2 GHz input clock: 0.5 ns period, rising edges at 0.25 + 0.5*k ns.
  always #0.25 clk_in = ~clk_in;

  fdiv16_sync #(.N_BITS(4)) dut4 (
    .in(clk_in), .rst_n(rst_n), .en(en), .out(out4), .taps(taps4), .cnt(cnt4)
  );
  fdiv16_sync #(.N_BITS(1)) dut1 (
    .in(clk_in), .rst_n(rst_n), .en(en), .out(out1), .taps(taps1), .cnt(cnt1)
  );
  fdiv16_sync #(.N_BITS(8)) dut8 (
    .in(clk_in), .rst_n(rst_n), .en(en), .out(out8), .taps(taps8), .cnt(cnt8)
  );

  // Reference: number of enabled rising edges since the last reset.
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) n_en = 0;
    else if (en === 1'b1) n_en = n_en + 1;
  end

  always @(posedge clk_in) t_pos = $realtime;

  // Edge-time recorder for the N_BITS=4 taps: first two rises and alignment to input edges.
  always @(taps4) begin
    if (rec) begin
      for (int k = 0; k < 4; k++) begin
        if (taps4[k] !== taps_prev[k]) begin
          if ($realtime != t_pos) misaligned++;
          if (taps4[k] === 1'b1) begin
            if (tap_nr[k] == 0) tap_r0[k] = $realtime;
            else if (tap_nr[k] == 1) tap_r1[k] = $realtime;
            tap_nr[k]++;
          end
        end
      end
    end
    taps_prev = taps4;
  end

  task automatic update_rec(inout edge_rec_t r, input logic v);
    if (v === 1'b1) begin
      if (r.nr == 0) r.r0 = $realtime;
      else if (r.nr == 1) r.r1 = $realtime;
      r.nr++;
    end else if (v === 1'b0 && r.nr == 1 && r.nf == 0) begin
      r.f0 = $realtime;
      r.nf++;
    end
  endtask

  always @(out4) if (rec) update_rec(rec4, out4);
  always @(out1) if (rec) update_rec(rec1, out1);
  always @(out8) if (rec) update_rec(rec8, out8);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $realtime);
    end
  endtask

  task automatic check_t(input string name, input realtime act, input realtime exp);
    n_checks++;
    if (act < exp - 0.001 || act > exp + 0.001) begin
      n_fail++;
      $display("FAIL %s: actual %0.3f ns required %0.3f ns", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned n_bits);
    return n_en % div_ratio(n_bits);
  endfunction

  // Output is high during the second half of each division period.
  function automatic logic [31:0] exp_out(input int unsigned n_bits);
    return 32'((n_en % div_ratio(n_bits)) >= (div_ratio(n_bits) / 2));
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".cnt4"},  32'(cnt4),  exp_cnt(4));
    check({tag, ".taps4"}, 32'(taps4), exp_cnt(4));
    check({tag, ".out4"},  32'(out4),  exp_out(4));
    check({tag, ".cnt1"},  32'(cnt1),  exp_cnt(1));
    check({tag, ".taps1"}, 32'(taps1), exp_cnt(1));
    check({tag, ".out1"},  32'(out1),  exp_out(1));
    check({tag, ".cnt8"},  32'(cnt8),  exp_cnt(8));
    check({tag, ".taps8"}, 32'(taps8), exp_cnt(8));
    check({tag, ".out8"},  32'(out8),  exp_out(8));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cnt4"},  32'(cnt4),  32'd0);
    check({tag, ".taps4"}, 32'(taps4), 32'd0);
    check({tag, ".out4"},  32'(out4),  32'd0);
    check({tag, ".cnt1"},  32'(cnt1),  32'd0);
    check({tag, ".out1"},  32'(out1),  32'd0);
    check({tag, ".cnt8"},  32'(cnt8),  32'd0);
    check({tag, ".out8"},  32'(out8),  32'd0);
  endtask

  initial begin
    // {en, enabled-edge count, expected cnt, expected out} applied back to back after reset.
    vecs[0] = '{1'b1, 6, 6,  1'b0};
    vecs[1] = '{1'b0, 5, 6,  1'b0};
    vecs[2] = '{1'b1, 1, 7,  1'b0};
    vecs[3] = '{1'b1, 1, 8,  1'b1};
    vecs[4] = '{1'b1, 7, 15, 1'b1};
    vecs[5] = '{1'b1, 1, 0,  1'b0};
    vecs[6] = '{1'b0, 3, 0,  1'b0};
    vecs[7] = '{1'b1, 3, 3,  1'b0};
    vecs[8] = '{1'b1, 8, 11, 1'b1};

    rst_n = 1'b0;
    en    = 1'b1;
    #0.1;
    check_zero("reset_before_first_edge");
    #10;

    // Free run from reset release: first period, tap periods, sweep instance periods.
    @(negedge clk_in);
    rec   = 1'b1;
    t_rel = $realtime;
    rst_n = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk_in);
      if (i <= 16) check($sformatf("first_period.out4[%0d]", i), 32'(out4), 32'((i % 16) >= 8));
      if (i <= 64) check_all("free_run");
    end
    rec = 1'b0;
    check_t("out4.first_rise_after_release", rec4.r0 - t_rel, 3.75);
    check_t("out4.period", rec4.r1 - rec4.r0, 8.0);
    check_t("out4.high",   rec4.f0 - rec4.r0, 4.0);
    check_t("out1.period", rec1.r1 - rec1.r0, 1.0);
    check_t("out1.high",   rec1.f0 - rec1.r0, 0.5);
    check_t("out8.period", rec8.r1 - rec8.r0, 128.0);
    check_t("out8.high",   rec8.f0 - rec8.r0, 64.0);
    for (int k = 0; k < 4; k++)
      check_t($sformatf("taps4[%0d].period", k), tap_r1[k] - tap_r0[k], 0.5 * real'(2 ** (k + 1)));
    check("taps4.edges_off_input_edge", 32'(misaligned), 32'd0);

    // Table-driven enable holds and wrap-around, starting from a fresh reset.
    @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int v = 0; v < 9; v++) begin
      en = vecs[v].en;
      repeat (vecs[v].cycles) @(negedge clk_in);
      check($sformatf("vec%0d.cnt4", v),  32'(cnt4),  32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d.taps4", v), 32'(taps4), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d.out4", v),  32'(out4),  32'(vecs[v].exp_out));
      check_all($sformatf("vec%0d", v));
    end

    // cnt is 11 here: asynchronous reset between edges, then restart of the phase.
    #0.1;
    rst_n = 1'b0;
    #0.01;
    check_zero("async_reset_mid_period");
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk_in);
      check($sformatf("after_reset.out4[%0d]", i), 32'(out4), 32'((i % 16) >= 8));
    end

    // Random enable with occasional asynchronous resets.
    for (int i = 0; i < 500; i++) begin
      en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) begin
        #0.1;
        rst_n = 1'b0;
        #0.05;
        check_zero("random_reset");
        @(negedge clk_in);
        rst_n = 1'b1;
      end else begin
        @(negedge clk_in);
      end
      check_all("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
